// File: rtl/seq_mult_nxn_pkg.sv
// Shared types and elaboration helpers for the sequential N x N multiplier.
// Holds the FSM encoding and the slice-count / counter-width calculations.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int calc_n(input int data_w, input int slice_w);
    int n;
    if (slice_w < 1) begin
      n = 1;
    end else begin
      n = data_w / slice_w;
    end
    return (n < 1) ? 1 : n;
  endfunction

  // Width of the partial-product index t = 0 .. N*N-1 (at least one bit).
  function automatic int calc_idx_w(input int n);
    return ((n * n) > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int calc_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_nxn_slice.sv
// Combinational SLICE_W x SLICE_W -> 2*SLICE_W unsigned multiplier.
// Instantiated once and time-shared by seq_mult_nxn.
module slice_mult #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0]   i_a,
  input  logic [SLICE_W-1:0]   i_b,
  output logic [2*SLICE_W-1:0] o_p
);

  localparam int PP_W = 2 * SLICE_W;

  assign o_p = PP_W'(i_a) * PP_W'(i_b);

endmodule

// File: rtl/seq_mult_nxn.sv
// Sequential DATA_W x DATA_W multiplier built from one slice multiplier with
// shift-and-accumulate. Define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_mult_nxn
  import seq_mult_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   dataa,
  input  logic [DATA_W-1:0]   datab,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int N     = calc_n(DATA_W, SLICE_W);
  localparam int NN    = N * N;
  localparam int IDX_W = calc_idx_w(N);
  localparam int SEL_W = calc_sel_w(N);
  localparam int PW    = 2 * DATA_W;
  localparam int PP_W  = 2 * SLICE_W;

  if ((SLICE_W < 1) || (DATA_W < 1) || ((DATA_W % SLICE_W) != 0)) begin : g_param_check
    $error("seq_mult_nxn: DATA_W must be a positive multiple of SLICE_W");
  end

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [PW-1:0]       r_acc;
  logic [IDX_W-1:0]    r_idx;
  logic [SEL_W-1:0]    r_i;
  logic [SEL_W-1:0]    r_j;
  logic                r_busy;
  logic                r_done;
  logic [PW-1:0]       r_product;

  logic [SLICE_W-1:0]  w_a_slice;
  logic [SLICE_W-1:0]  w_b_slice;
  logic [PP_W-1:0]     w_pp;
  logic [PW-1:0]       w_pp_shifted;
  logic [PW-1:0]       w_result;
  logic                w_last;
  logic [DATA_W-1:0]   w_a_cap;
  logic [DATA_W-1:0]   w_b_cap;

`ifdef SEQ_MULT_SIGNED_EN
  logic                r_sign;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1'b1)) : v;
  endfunction

  assign w_a_cap  = magnitude(dataa);
  assign w_b_cap  = magnitude(datab);
  assign w_result = r_sign ? (~r_acc + PW'(1'b1)) : r_acc;
`else
  assign w_a_cap  = dataa;
  assign w_b_cap  = datab;
  assign w_result = r_acc;
`endif

  slice_mult #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .i_a (w_a_slice),
    .i_b (w_b_slice),
    .o_p (w_pp)
  );

  // Select the current operand slices and align the partial product.
  always_comb begin
    w_a_slice    = SLICE_W'(r_a >> (int'(r_i) * SLICE_W));
    w_b_slice    = SLICE_W'(r_b >> (int'(r_j) * SLICE_W));
    w_pp_shifted = PW'(w_pp) << ((int'(r_i) + int'(r_j)) * SLICE_W);
    w_last       = (r_idx == IDX_W'(NN - 1));
  end

  // Control FSM, operand capture, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= w_a_cap;
            r_b     <= w_b_cap;
`ifdef SEQ_MULT_SIGNED_EN
            r_sign  <= dataa[DATA_W-1] ^ datab[DATA_W-1];
`endif
            r_acc   <= '0;
            r_idx   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_acc <= r_acc + w_pp_shifted;
          if (w_last) begin
            r_idx   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1'b1);
            // i walks the A slices fastest; j steps once per full row.
            if (r_i == SEL_W'(N - 1)) begin
              r_i <= '0;
              r_j <= r_j + SEL_W'(1'b1);
            end else begin
              r_i <= r_i + SEL_W'(1'b1);
            end
          end
        end
        ST_DONE: begin
          r_product <= w_result;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Directed self-checking bench for seq_mult_nxn (8x8 from 4x4 slices).
// Expected values follow SEQ_MULT_SIGNED_EN when it is defined.
module tb_seq_mult_nxn;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp;
  int n_err;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [15:0] EXP_200_150 = 16'h1730;
  localparam logic [15:0] EXP_FF_FF   = 16'h0001;
  localparam logic [15:0] EXP_FD_05   = 16'hFFF1;
`else
  localparam logic [15:0] EXP_200_150 = 16'h7530;
  localparam logic [15:0] EXP_FF_FF   = 16'hFE01;
  localparam logic [15:0] EXP_FD_05   = 16'd1265;
`endif

  seq_mult_nxn #(
    .DATA_W  (8),
    .SLICE_W (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
    dataa = a;
    datab = b;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    p = product;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dataa = 8'd0;
    datab = 8'd0;
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: product=%h busy=%b done=%b want 0000/0/0",
                 c, product, busy, done);
      end
      step();
    end
  endtask

  task automatic test_basic();
    dataa = 8'd200;
    datab = 8'd150;
    start = 1'b1;
    step();
    start = 1'b0;
    dataa = 8'hAA;
    datab = 8'h55;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy edge k+%0d: busy=%b done=%b want 1/0", c, busy, done);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== EXP_200_150) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b product=%h want 1/0/%h",
               done, busy, product, EXP_200_150);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || product !== EXP_200_150) begin
      n_err++;
      $display("FAIL basic_hold: done=%b product=%h want 0/%h", done, product, EXP_200_150);
    end
  endtask

  task automatic test_carry();
    logic [15:0] p;
    int          lat;
    do_op(8'd255, 8'd255, p, lat);
    n_cmp++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL carry_latency: got %0d want 5", lat);
    end
    n_cmp++;
    if (p !== EXP_FF_FF) begin
      n_err++;
      $display("FAIL carry_ff_ff: got %h want %h", p, EXP_FF_FF);
    end
    do_op(8'd0, 8'd77, p, lat);
    n_cmp++;
    if (p !== 16'h0000 || lat !== 5) begin
      n_err++;
      $display("FAIL zero_operand: product=%h lat=%0d want 0000/5", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    step();
    dataa = 8'd12;
    datab = 8'd11;
    start = 1'b1;
    step();
    dataa = 8'd99;
    datab = 8'd99;
    step();
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy: done=%b busy=%b want 0/1", done, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || product !== 16'd132) begin
      n_err++;
      $display("FAIL b2b_first: done=%b product=%h want 1/%h", done, product, 16'd132);
    end
    dataa = 8'd7;
    datab = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: done=%b busy=%b want 0/1", done, busy);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_single_done cyc%0d: done=%b want 0", c, done);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || product !== 16'd63) begin
      n_err++;
      $display("FAIL b2b_second: done=%b product=%h want 1/%h", done, product, 16'd63);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int          lat;
    step();
    dataa = 8'd200;
    datab = 8'd150;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: product=%h busy=%b done=%b want 0000/0/0",
               product, busy, done);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_nodone cyc%0d: done=%b busy=%b want 0/0", c, done, busy);
      end
    end
    reset = 1'b1;
    start = 1'b1;
    dataa = 8'd3;
    datab = 8'd3;
    step();
    reset = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wins: busy=%b done=%b want 0/0", busy, done);
    end
    do_op(8'd13, 8'd17, p, lat);
    n_cmp++;
    if (p !== 16'd221 || lat !== 5) begin
      n_err++;
      $display("FAIL after_reset_13x17: product=%h lat=%0d want %h/5", p, lat, 16'd221);
    end
  endtask

  task automatic test_signed_vectors();
    logic [15:0] p;
    int          lat;
    do_op(8'h80, 8'h80, p, lat);
    n_cmp++;
    if (p !== 16'h4000) begin
      n_err++;
      $display("FAIL vec_80_80: got %h want 4000", p);
    end
    do_op(8'hFD, 8'h05, p, lat);
    n_cmp++;
    if (p !== EXP_FD_05 || lat !== 5) begin
      n_err++;
      $display("FAIL vec_fd_05: product=%h lat=%0d want %h/5", p, lat, EXP_FD_05);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    dataa = 8'd0;
    datab = 8'd0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid();
    test_signed_vectors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
